// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file write port among NREQ writeback units and keeps a WAW busy scoreboard.
// Latency: a grant in cycle N drives rf_we_o in N+1, and the busy bit drops in N+2. Build option REGFILE_WB_FIXED_PRIO_EN selects fixed priority.
// Backpressure: the output stage always accepts, so every cycle with a valid request grants exactly one requester. Issue stalls on a WAW hazard.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREQ = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   iss_valid_i,
   input  logic [4:0]             iss_rd_i,
   output logic                   iss_ready_o,
   output logic [31:0]            busy_o,
   input  logic [NREQ-1:0]        wb_valid_i,
   output logic [NREQ-1:0]        wb_ready_o,
   input  logic [5*NREQ-1:0]      wb_rd_i,
   input  logic [XLEN*NREQ-1:0]   wb_data_i,
   output logic                   rf_we_o,
   output logic [4:0]             rf_waddr_o,
   output logic [XLEN-1:0]        rf_wdata_o,
   output logic                   stray_wb_o
);

   localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [31:0]      busy_q, busy_d;
   logic             rf_we_q;
   logic [4:0]       rf_waddr_q;
   logic [XLEN-1:0]  rf_wdata_q;
   logic             stray_q;

   logic [NREQ-1:0]  gnt;
   logic             gnt_any;
   logic [RRW-1:0]   win;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;
   logic             iss_fire;
   logic             stray_d;

   // x0 never hazards, so issue is always allowed for rd == 0
   assign iss_ready_o = (iss_rd_i == 5'd0) || !busy_q[iss_rd_i];
   assign iss_fire    = iss_valid_i && iss_ready_o;

`ifdef REGFILE_WB_FIXED_PRIO_EN
   // Fixed priority: the lowest valid index wins
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      win     = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && wb_valid_i[k]) begin
            gnt_any = 1'b1;
            gnt[k]  = 1'b1;
            win     = RRW'(k);
         end
      end
   end
`else
   logic [RRW-1:0] rr_q;
   int             scan_idx;

   // Round-robin: scan from rr_q upward, wrapping modulo NREQ
   always_comb begin
      gnt      = '0;
      gnt_any  = 1'b0;
      win      = '0;
      scan_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(rr_q) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!gnt_any && wb_valid_i[scan_idx]) begin
            gnt_any       = 1'b1;
            gnt[scan_idx] = 1'b1;
            win           = RRW'(scan_idx);
         end
      end
   end

   // After a grant, the requester following the winner gets first claim next time
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (gnt_any) begin
         rr_q <= (win == RRW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
   end
`endif

   assign wb_ready_o = gnt;
   assign sel_rd     = wb_rd_i[int'(win)*5 +: 5];
   assign sel_data   = wb_data_i[int'(win)*XLEN +: XLEN];
   // A write to a register nobody is waiting on points at a pipeline bookkeeping bug upstream
   assign stray_d    = gnt_any && (sel_rd != 5'd0) && !busy_q[sel_rd];

   // Scoreboard next state: the retiring write clears first, then the issue sets, so a set wins on a collision
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
      if (iss_fire && (iss_rd_i != 5'd0)) busy_d[iss_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Registered write stage: address and data hold when idle, and an x0 grant is consumed without a write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         stray_q    <= 1'b0;
      end else begin
         stray_q <= stray_d;
         if (gnt_any) begin
            rf_we_q    <= (sel_rd != 5'd0);
            rf_waddr_q <= sel_rd;
            rf_wdata_q <= sel_data;
         end else begin
            rf_we_q    <= 1'b0;
         end
      end
   end

   assign busy_o     = busy_q;
   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign stray_wb_o = stray_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single path, arbitration order, WAW stall,
// collision of a scoreboard set with a clear, stray writes, and x0 grants.
// Inputs are driven 1 ns after the rising edge, and outputs are checked before the next edge.
module tb_regfile_wb_arbiter;
   localparam int XLEN = 32;
   localparam int NREQ = 3;

   logic                  clk_i;
   logic                  rst_ni;
   logic                  iss_valid_i;
   logic [4:0]            iss_rd_i;
   logic                  iss_ready_o;
   logic [31:0]           busy_o;
   logic [NREQ-1:0]       wb_valid_i;
   logic [NREQ-1:0]       wb_ready_o;
   logic [5*NREQ-1:0]     wb_rd_i;
   logic [XLEN*NREQ-1:0]  wb_data_i;
   logic                  rf_we_o;
   logic [4:0]            rf_waddr_o;
   logic [XLEN-1:0]       rf_wdata_o;
   logic                  stray_wb_o;

   int vectors = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .iss_valid_i (iss_valid_i),
      .iss_rd_i    (iss_rd_i),
      .iss_ready_o (iss_ready_o),
      .busy_o      (busy_o),
      .wb_valid_i  (wb_valid_i),
      .wb_ready_o  (wb_ready_o),
      .wb_rd_i     (wb_rd_i),
      .wb_data_i   (wb_data_i),
      .rf_we_o     (rf_we_o),
      .rf_waddr_o  (rf_waddr_o),
      .rf_wdata_o  (rf_wdata_o),
      .stray_wb_o  (stray_wb_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] rr_exp;
      rst_ni = 1'b0; iss_valid_i = 1'b0; iss_rd_i = 5'd0;
      wb_valid_i = '0; wb_rd_i = '0; wb_data_i = '0;
      tick(); tick();
      // reset state
      chk("rst_busy",  busy_o, 0);
      chk("rst_we",    rf_we_o, 0);
      chk("rst_waddr", rf_waddr_o, 0);
      chk("rst_wdata", rf_wdata_o, 0);
      chk("rst_stray", stray_wb_o, 0);
      chk("rst_wbrdy", wb_ready_o, 0);
      iss_rd_i = 5'd17; #1;
      chk("rst_issrdy", iss_ready_o, 1);
      iss_rd_i = 5'd0;
      rst_ni = 1'b1;
      tick();

      // arbitration order with all requesters valid (x0 targets, no writes)
      wb_valid_i = 3'b111;
      wb_data_i  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      for (int i = 0; i < 6; i++) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
         rr_exp = 3'b001;
`else
         rr_exp = 3'b001 << (i % 3);
`endif
         #1;
         chk("rr_grant", wb_ready_o, rr_exp);
         tick();
         chk("rr_no_we", rf_we_o, 0);
         chk("rr_no_stray", stray_wb_o, 0);
      end
      wb_valid_i = '0;
      tick();

      // single path: issue x5, requester 1 writes it back
      iss_valid_i = 1'b1; iss_rd_i = 5'd5; #1;
      chk("sp_issrdy", iss_ready_o, 1);
      tick();
      iss_valid_i = 1'b0;
      wb_valid_i = 3'b010; wb_rd_i[9:5] = 5'd5; wb_data_i[63:32] = 32'hDEADBEEF; #1;
      chk("sp_grant", wb_ready_o, 3'b010);
      chk("sp_busy_set", busy_o, 32'h0000_0020);
      tick();
      wb_valid_i = '0;
      chk("sp_we", rf_we_o, 1);
      chk("sp_waddr", rf_waddr_o, 5);
      chk("sp_wdata", rf_wdata_o, 32'hDEADBEEF);
      chk("sp_stray", stray_wb_o, 0);
      chk("sp_busy_n1", busy_o, 32'h0000_0020);
      tick();
      chk("sp_busy_n2", busy_o, 0);
      chk("sp_we_off", rf_we_o, 0);
      chk("sp_waddr_hold", rf_waddr_o, 5);

      // WAW stall on x7
      iss_valid_i = 1'b1; iss_rd_i = 5'd7; #1;
      chk("waw_first", iss_ready_o, 1);
      tick();
      chk("waw_busy", busy_o, 32'h0000_0080);
      #1;
      chk("waw_stall", iss_ready_o, 0);
      iss_rd_i = 5'd0; #1;
      chk("waw_x0_rdy", iss_ready_o, 1);
      tick();
      chk("waw_x0_nochg", busy_o, 32'h0000_0080);
      iss_rd_i = 5'd7;
      wb_valid_i = 3'b001; wb_rd_i[4:0] = 5'd7; wb_data_i[31:0] = 32'h7777_0007; #1;
      chk("waw_stall_n", iss_ready_o, 0);
      chk("waw_grant", wb_ready_o, 3'b001);
      tick();
      wb_valid_i = '0;
      chk("waw_stall_n1", iss_ready_o, 0);
      chk("waw_we", rf_we_o, 1);
      chk("waw_waddr", rf_waddr_o, 7);
      chk("waw_wdata", rf_wdata_o, 32'h7777_0007);
      tick();
      chk("waw_busy_clr", busy_o, 0);
      chk("waw_rdy_n2", iss_ready_o, 1);
      tick();
      iss_valid_i = 1'b0;
      chk("waw_reissue", busy_o, 32'h0000_0080);

      // stray write to x9 colliding with an issue to x9
      wb_valid_i = 3'b100; wb_rd_i[14:10] = 5'd9; wb_data_i[95:64] = 32'h9999_0009; #1;
      chk("st_grant", wb_ready_o, 3'b100);
      tick();
      wb_valid_i = '0;
      chk("st_we", rf_we_o, 1);
      chk("st_waddr", rf_waddr_o, 9);
      chk("st_pulse", stray_wb_o, 1);
      iss_valid_i = 1'b1; iss_rd_i = 5'd9; #1;
      chk("st_issrdy", iss_ready_o, 1);
      tick();
      iss_valid_i = 1'b0;
      chk("setclr_busy", busy_o, 32'h0000_0280);
      chk("st_pulse_end", stray_wb_o, 0);
      chk("st_we_end", rf_we_o, 0);

      // x0 grant: consumed, no write, no pulse
      wb_valid_i = 3'b001; wb_rd_i[4:0] = 5'd0; wb_data_i[31:0] = 32'h0000_CAFE; #1;
      chk("x0_grant", wb_ready_o, 3'b001);
      tick();
      wb_valid_i = '0;
      chk("x0_we", rf_we_o, 0);
      chk("x0_stray", stray_wb_o, 0);
      chk("x0_busy", busy_o, 32'h0000_0280);
      chk("x0_wdata", rf_wdata_o, 32'h0000_CAFE);

      // asynchronous reset mid-run with busy bits set
      #2;
      rst_ni = 1'b0; #1;
      chk("mr_busy", busy_o, 0);
      chk("mr_waddr", rf_waddr_o, 0);
      chk("mr_wdata", rf_wdata_o, 0);
      chk("mr_we", rf_we_o, 0);
      iss_rd_i = 5'd9; #1;
      chk("mr_issrdy", iss_ready_o, 1);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("mr_busy_after", busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
